// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and default width for the serial subtractor
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/fullsubstractor.sv
// rtl/fullsubstractor.sv - one-bit full subtractor cell: a - b - bin
module fullsubstractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first unsigned subtractor, one bit per clock
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cell_diff;
    logic             cell_borrow;

    fullsubstractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .diff (cell_diff),
        .bout (cell_borrow)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                res_d = {cell_diff, res_q[WIDTH-1:1]};
                br_d  = cell_borrow;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                // Last bit: publish the completed word so d/bout only move here.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    d_d     = {cell_diff, res_q[WIDTH-1:1]};
                    bout_d  = cell_borrow;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int base;
    int cyc;
    logic [W:0] exp_q[$];
    logic [W:0] exp_v;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    endfunction

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (n >= 30) check({tag, "_timeout"}, 32'd1, 32'd0);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_d"}, 32'(d), 32'(exp_v[W-1:0]));
        check({tag, "_bout"}, 32'(bout), 32'(exp_v[W]));
    endtask

    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int n;
        @(negedge clk);
        a = x; b = y; bin = bi; start = 1'b1;
        exp_q.push_back(model(x, y, bi));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(tag, n);
        check({tag, "_latency"}, 32'(n), 32'(W));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;

        op("basic", 8'h5A, 8'h3C, 1'b0);
        op("underflow", 8'h00, 8'h01, 1'b0);
        op("bin_cancel", 8'h80, 8'h7F, 1'b1);
        op("fullscale", 8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++)
            op("rand", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        // results hold through idle
        op("hold", 8'h0C, 8'h05, 1'b1);
        repeat (4) @(negedge clk);
        check("hold_d", 32'(d), 32'h06);

        // start while busy is ignored
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h10, 8'h01, 1'b0));
        base = done_cnt;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h00; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", cyc);
        repeat (15) @(negedge clk);
        check("busy_start_pulses", 32'(done_cnt - base), 32'd1);
        check("busy_start_idle", 32'(busy), 32'd0);
        check("busy_start_keep", 32'(d), 32'h0F);

        // asynchronous reset mid-operation
        @(negedge clk);
        a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        base = done_cnt;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_d", 32'(d), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        rst_n = 1'b1;
        op("after_reset", 8'h05, 8'h03, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
